// File: rtl/heater_pkg.sv
// Shared definitions for the heater command controller: word layout,
// opcodes, mode and reply-FSM encodings, status bit positions and reset values.
package heater_pkg;

  localparam int WIDTH = 12;

  // Reset defaults and limits (degC unless noted)
  localparam logic [7:0]  SP_DEFAULT   = 8'd50;
  localparam logic [3:0]  HYST_DEFAULT = 4'd2;
  localparam logic [7:0]  SP_MIN       = 8'd20;
  localparam logic [7:0]  SP_MAX       = 8'd90;
  localparam logic [11:0] OVERTEMP     = 12'd380;  // TEMP units, 0.25 degC/LSB

  // Opcodes carried in word bits [11:8]
  localparam logic [3:0] OP_NOP       = 4'h0;
  localparam logic [3:0] OP_WR_SP     = 4'h1;
  localparam logic [3:0] OP_WR_HYST   = 4'h2;
  localparam logic [3:0] OP_SET_MODE  = 4'h3;
  localparam logic [3:0] OP_RD_TEMP   = 4'h4;
  localparam logic [3:0] OP_RD_STATUS = 4'h5;
  localparam logic [3:0] OP_RD_SP     = 4'h6;
  localparam logic [3:0] OP_CLR_FAULT = 4'h7;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_AUTO  = 2'd1,
    MODE_FORCE = 2'd2
  } mode_t;
  localparam logic [1:0] MODE_INVALID = 2'd3;

  // Status reply layout
  localparam int ST_BIT_FAULT   = 11;
  localparam int ST_BIT_HEATER  = 10;
  localparam int ST_BIT_MODE_LO = 8;
  localparam int ST_BIT_OVR     = 7;
  localparam int ST_BIT_ERR_LO  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } reply_state_t;

  // Last count value in SEND (start bit + WIDTH data bits) and in GAP
  localparam logic [3:0] SEND_LAST = 4'(WIDTH);
  localparam logic [3:0] GAP_LAST  = 4'd1;

  function automatic logic [7:0] clamp_sp(input logic [7:0] val);
    if (val < SP_MIN) return SP_MIN;
    if (val > SP_MAX) return SP_MAX;
    return val;
  endfunction

endpackage

// File: rtl/heater_cmd_ctrl_if.sv
// Word-level link between the SPI slave front end and the command controller.
// master = SPI front end (delivers received words), slave = controller.
interface heater_cmd_ctrl_if;
  import heater_pkg::*;

  logic [WIDTH-1:0] DATA_MOSI;
  logic             dflag;
  logic [WIDTH-1:0] DATA_MISO;
  logic             MISOflag;

  modport master (
    output DATA_MOSI,
    output dflag,
    input  DATA_MISO,
    input  MISOflag
  );

  modport slave (
    input  DATA_MOSI,
    input  dflag,
    output DATA_MISO,
    output MISOflag
  );

endinterface

// File: rtl/heater_thermostat.sv
// Hysteresis thermostat with mode gating and a sticky over-temperature latch.
// Demand is remembered separately from the fault so that clearing a fault
// restores the heater to whatever the thermostat last asked for.
module heater_thermostat
  import heater_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [11:0] TEMP,
  input  logic        TEMP_VALID,
  input  logic [7:0]  SETPOINT,
  input  logic [3:0]  hyst,
  input  mode_t       mode,
  input  logic        clr_fault_req,
  output logic        HEATER_EN,
  output logic        FAULT
);

  logic [7:0] lo_deg;
  logic [9:0] lo_x4;
  logic [9:0] sp_x4;
  logic       demand_reg, demand_next;
  logic       fault_reg, fault_next;
  logic       heater_reg;

  // Thresholds in TEMP units, lower threshold floored at zero
  always_comb begin
    lo_deg = (SETPOINT > {4'b0000, hyst}) ? (SETPOINT - {4'b0000, hyst}) : 8'd0;
    lo_x4  = {lo_deg, 2'b00};
    sp_x4  = {SETPOINT, 2'b00};
  end

  // Next demand and fault; a fresh over-temperature reading beats a clear
  always_comb begin
    demand_next = demand_reg;
    fault_next  = fault_reg;
    if (TEMP_VALID) begin
      case (mode)
        MODE_OFF:   demand_next = 1'b0;
        MODE_FORCE: demand_next = 1'b1;
        MODE_AUTO: begin
          if (TEMP < {2'b00, lo_x4})
            demand_next = 1'b1;
          else if (TEMP >= {2'b00, sp_x4})
            demand_next = 1'b0;
        end
        default: demand_next = 1'b0;
      endcase
    end
    if (clr_fault_req)
      fault_next = 1'b0;
    if (TEMP_VALID && (TEMP >= OVERTEMP))
      fault_next = 1'b1;
  end

  // Register demand, fault and the gated heater drive
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      demand_reg <= 1'b0;
      fault_reg  <= 1'b0;
      heater_reg <= 1'b0;
    end else begin
      demand_reg <= demand_next;
      fault_reg  <= fault_next;
      heater_reg <= demand_next & ~fault_next;
    end
  end

  assign HEATER_EN = heater_reg;
  assign FAULT     = fault_reg;

endmodule

// File: rtl/heater_cmd_ctrl.sv
// Command decoder and reply engine behind the SPI slave. Decodes received
// words into register writes / read requests, serialises replies through a
// SEND/GAP framing FSM with a one-deep pending buffer, and hosts the thermostat.
module heater_cmd_ctrl
  import heater_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  heater_cmd_ctrl_if.slave  spi,
  input  logic [11:0]       TEMP,
  input  logic              TEMP_VALID,
  output logic [7:0]        SETPOINT,
  output logic              HEATER_EN,
  output logic              FAULT
);

  logic [3:0]       opcode;
  logic [7:0]       payload;

  logic [7:0]       sp_reg;
  logic [3:0]       hyst_reg;
  mode_t            mode_reg;
  logic [3:0]       err_cnt_reg;
  logic             ovr_reg;
  logic [11:0]      temp_latched_reg;

  reply_state_t     state_reg;
  logic [3:0]       cnt_reg;
  logic [WIDTH-1:0] miso_reg;
  logic             flag_reg;
  logic             pend_valid_reg;
  logic [WIDTH-1:0] pend_data_reg;
  logic             pend_status_reg;

  logic [WIDTH-1:0] status_word;
  logic             is_read;
  logic             rd_status;
  logic [WIDTH-1:0] rd_data;
  logic             bad_cmd;
  logic             clr_fault_req;
  logic             launch;
  logic             load_en;
  logic [WIDTH-1:0] load_data;
  logic             load_status;
  logic             pend_wr;
  logic             pend_clr;
  logic             drop;

  assign opcode  = spi.DATA_MOSI[11:8];
  assign payload = spi.DATA_MOSI[7:0];

  // Status word as seen before this edge's updates
  always_comb begin
    status_word                         = '0;
    status_word[ST_BIT_FAULT]           = FAULT;
    status_word[ST_BIT_HEATER]          = HEATER_EN;
    status_word[ST_BIT_MODE_LO +: 2]    = mode_reg;
    status_word[ST_BIT_OVR]             = ovr_reg;
    status_word[ST_BIT_ERR_LO +: 4]     = err_cnt_reg;
  end

  // Decode the word on the dflag cycle into read requests and error events
  always_comb begin
    is_read       = 1'b0;
    rd_status     = 1'b0;
    rd_data       = '0;
    bad_cmd       = 1'b0;
    clr_fault_req = 1'b0;
    if (spi.dflag) begin
      case (opcode)
        OP_NOP, OP_WR_SP, OP_WR_HYST: ;
        OP_SET_MODE: bad_cmd = (payload[1:0] == MODE_INVALID);
        OP_RD_TEMP: begin
          is_read = 1'b1;
          rd_data = TEMP_VALID ? TEMP : temp_latched_reg;
        end
        OP_RD_STATUS: begin
          is_read   = 1'b1;
          rd_status = 1'b1;
          rd_data   = status_word;
        end
        OP_RD_SP: begin
          is_read = 1'b1;
          rd_data = {4'b0000, sp_reg};
        end
        OP_CLR_FAULT: begin
          if (temp_latched_reg < OVERTEMP)
            clr_fault_req = 1'b1;
          else
            bad_cmd = 1'b1;
        end
        default: bad_cmd = 1'b1;
      endcase
    end
  end

  // Link is free to start a reply in IDLE or on the last GAP cycle; the
  // pending entry always goes out before a newly arriving read.
  always_comb begin
    launch      = (state_reg == ST_IDLE) || ((state_reg == ST_GAP) && (cnt_reg == GAP_LAST));
    load_en     = launch && (pend_valid_reg || is_read);
    load_data   = pend_valid_reg ? pend_data_reg : rd_data;
    load_status = pend_valid_reg ? pend_status_reg : rd_status;
    pend_wr     = is_read && (pend_valid_reg == launch);
    pend_clr    = pend_valid_reg && launch && !is_read;
    drop        = is_read && pend_valid_reg && !launch;
  end

  // Configuration, error counter, overflow flag and latched temperature
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sp_reg           <= SP_DEFAULT;
      hyst_reg         <= HYST_DEFAULT;
      mode_reg         <= MODE_OFF;
      err_cnt_reg      <= '0;
      ovr_reg          <= 1'b0;
      temp_latched_reg <= '0;
    end else begin
      if (spi.dflag && (opcode == OP_WR_SP))
        sp_reg <= clamp_sp(payload);
      if (spi.dflag && (opcode == OP_WR_HYST))
        hyst_reg <= payload[3:0];
      if (spi.dflag && (opcode == OP_SET_MODE) && (payload[1:0] != MODE_INVALID))
        mode_reg <= mode_t'(payload[1:0]);
      if (TEMP_VALID)
        temp_latched_reg <= TEMP;
      if ((bad_cmd || drop) && (err_cnt_reg != 4'hF))
        err_cnt_reg <= err_cnt_reg + 4'd1;
      if (drop)
        ovr_reg <= 1'b1;
      else if (load_en && load_status)
        ovr_reg <= 1'b0;
    end
  end

  // Reply FSM with registered DATA_MISO/MISOflag and the pending buffer
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      miso_reg        <= '0;
      flag_reg        <= 1'b0;
      pend_valid_reg  <= 1'b0;
      pend_data_reg   <= '0;
      pend_status_reg <= 1'b0;
    end else begin
      if (load_en) begin
        state_reg <= ST_SEND;
        cnt_reg   <= '0;
        miso_reg  <= load_data;
        flag_reg  <= 1'b1;
      end else begin
        case (state_reg)
          ST_SEND: begin
            if (cnt_reg == SEND_LAST) begin
              state_reg <= ST_GAP;
              cnt_reg   <= '0;
              flag_reg  <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + 4'd1;
            end
          end
          ST_GAP: begin
            if (cnt_reg == GAP_LAST)
              state_reg <= ST_IDLE;
            else
              cnt_reg <= cnt_reg + 4'd1;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
      if (pend_wr) begin
        pend_valid_reg  <= 1'b1;
        pend_data_reg   <= rd_data;
        pend_status_reg <= rd_status;
      end else if (pend_clr) begin
        pend_valid_reg <= 1'b0;
      end
    end
  end

  assign spi.DATA_MISO = miso_reg;
  assign spi.MISOflag  = flag_reg;
  assign SETPOINT      = sp_reg;

  heater_thermostat u_thermostat (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .TEMP          (TEMP),
    .TEMP_VALID    (TEMP_VALID),
    .SETPOINT      (sp_reg),
    .hyst          (hyst_reg),
    .mode          (mode_reg),
    .clr_fault_req (clr_fault_req),
    .HEATER_EN     (HEATER_EN),
    .FAULT         (FAULT)
  );

endmodule
